// File: rtl/alu_pkg.sv
// Shared types and constants for the 6-bit ALU and its downstream result buffer.
package alu_pkg;

  localparam int ALU_W = 6;
  localparam int OP_W  = 2;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ALU_W-1:0] res;
    logic             cout;
  } alu_result_t;

  localparam logic [OP_W-1:0] OP_00 = 2'b00;
  localparam logic [OP_W-1:0] OP_01 = 2'b01;
  localparam logic [OP_W-1:0] OP_10 = 2'b10;
  localparam logic [OP_W-1:0] OP_11 = 2'b11;

endpackage

// File: rtl/alu_result_fifo_mem.sv
// DEPTH x alu_result_t storage: synchronous write, asynchronous read.
// Contents are deliberately left unreset; validity is tracked by the owner's pointers.
module alu_result_fifo_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  alu_result_t              i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output alu_result_t              o_rdata
);

  alu_result_t r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// Captures ALU results into a small FIFO with valid/ready on both sides and
// keeps a saturating count of accepted results that carried out.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_res,
  input  logic                     in_cout,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_res,
  output logic                     out_cout,
  output logic [1:0]               out_op,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         carry_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_carry;

  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_push;
  logic        w_pop;
  logic        w_we;
  alu_result_t w_wdata;
  alu_result_t w_rdata;

  // Handshake flags depend only on registered occupancy.
  assign w_in_ready  = (r_count != CW'(DEPTH));
  assign w_out_valid = (r_count != {CW{1'b0}});
  assign w_push      = in_valid && w_in_ready;
  assign w_pop       = w_out_valid && out_ready;
  assign w_we        = w_push && !clr;
  assign w_wdata     = {in_op, in_res, in_cout};

  alu_result_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // Pointers, occupancy and carry counter; clr outranks push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
      r_carry <= {CNT_W{1'b0}};
    end else if (clr) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
      r_carry <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && in_cout && (r_carry != {CNT_W{1'b1}})) begin
        r_carry <= r_carry + CNT_W'(1);
      end
    end
  end

  // Head entry is presented only while valid, otherwise zeros.
  always_comb begin
    out_res  = 6'd0;
    out_cout = 1'b0;
    out_op   = 2'b00;
    if (w_out_valid) begin
      out_res  = w_rdata.res;
      out_cout = w_rdata.cout;
      out_op   = w_rdata.op;
    end else begin
      out_res  = 6'd0;
      out_cout = 1'b0;
      out_op   = 2'b00;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign count       = r_count;
  assign carry_count = r_carry;

endmodule
